// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit positions and address-width helper for avalon_multi_timer.
// Defining TIMER_PWM_EN adds a compare/PWM page per channel above the global page.
package timer_pkg;

  localparam logic [1:0] REG_STATUS   = 2'd0;
  localparam logic [1:0] REG_CTRL     = 2'd1;
  localparam logic [1:0] REG_PERIOD   = 2'd2;
  localparam logic [1:0] REG_SNAP     = 2'd3;
  localparam logic [1:0] REG_IRQ_PEND = 2'd0;
  localparam logic [1:0] REG_CH_MASK  = 2'd1;
  localparam logic [1:0] REG_CMP      = 2'd3;

  localparam int STATUS_TO      = 0;
  localparam int STATUS_RUN     = 1;
  localparam int CTRL_ITO       = 0;
  localparam int CTRL_CONT      = 1;
  localparam int CTRL_START     = 2;
  localparam int CTRL_STOP      = 3;
  localparam int CTRL_PRESC_LSB = 8;
  // The global CH_MASK field shares the CTRL layout so START/STOP keep their bit positions.
  localparam int CH_MASK_LSB    = 8;

`ifdef TIMER_PWM_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif

  function automatic int calc_addr_w(input int num_ch, input bit pwm_en);
    return $clog2(pwm_en ? (2 * num_ch + 1) : (num_ch + 1)) + 2;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: prescaler, counter, RUN/TO flags, snapshot.
// With TIMER_PWM_EN it also holds a CMP register and a registered compare output.
module timer_channel
  import timer_pkg::*;
#(
  parameter int          CNT_W          = 32,
  parameter int          PRESC_W        = 8,
  parameter int unsigned DEFAULT_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_status,
  input  logic        wr_ctrl,
  input  logic        wr_period,
  input  logic        wr_snap,
`ifdef TIMER_PWM_EN
  input  logic        wr_cmp,
  output logic [31:0] cmp_rdata,
`endif
  input  logic [31:0] wdata,
  input  logic        g_start,
  input  logic        g_stop,
  input  logic [1:0]  reg_sel,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        pwm
);

  logic               to, run, ito, cont;
  logic [PRESC_W-1:0] presc, presc_cnt, presc_nxt;
  logic [CNT_W-1:0]   period, cnt, snap;
  logic               start, stop, tick, timeout;
  logic               unused_bits;

  assign start       = (wr_ctrl & wdata[CTRL_START]) | g_start;
  assign stop        = (wr_ctrl & wdata[CTRL_STOP]) | g_stop;
  // A START in the same write as a new PRESC must restart from the new value.
  assign presc_nxt   = wr_ctrl ? wdata[CTRL_PRESC_LSB +: PRESC_W] : presc;
  assign tick        = run & (presc_cnt == '0);
  assign timeout     = tick & (cnt == '0);
  assign irq         = to & ito;
  assign unused_bits = ^wdata;

  // NOTE: non-blocking assignments so every register in this block samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to        <= 1'b0;
      run       <= 1'b0;
      ito       <= 1'b0;
      cont      <= 1'b0;
      presc     <= '0;
      presc_cnt <= '0;
      period    <= CNT_W'(DEFAULT_PERIOD);
      cnt       <= CNT_W'(DEFAULT_PERIOD);
      snap      <= '0;
    end else begin
      if (wr_ctrl) begin
        ito   <= wdata[CTRL_ITO];
        cont  <= wdata[CTRL_CONT];
        presc <= wdata[CTRL_PRESC_LSB +: PRESC_W];
      end

      if (wr_period) begin
        period <= wdata[CNT_W-1:0];
        cnt    <= wdata[CNT_W-1:0];
      end else if (tick) begin
        cnt <= (cnt == '0) ? period : cnt - CNT_W'(1);
      end

      if (wr_period || start)
        presc_cnt <= presc_nxt;
      else if (run)
        presc_cnt <= (presc_cnt == '0) ? presc : presc_cnt - PRESC_W'(1);

      if (wr_period)
        run <= 1'b0;
      else if (start)
        run <= 1'b1;
      else if (stop || (timeout && !cont))
        run <= 1'b0;

      // A timeout in the same cycle as a clear leaves TO set.
      to <= timeout | (to & ~(wr_status & wdata[STATUS_TO]));

      if (wr_snap)
        snap <= cnt;
    end
  end

  // NOTE: default assignment first keeps this combinational block free of inferred latches.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: begin
        rdata[STATUS_TO]  = to;
        rdata[STATUS_RUN] = run;
      end
      REG_CTRL: begin
        rdata[CTRL_ITO]                     = ito;
        rdata[CTRL_CONT]                    = cont;
        rdata[CTRL_PRESC_LSB +: PRESC_W]    = presc;
      end
      REG_PERIOD: rdata[CNT_W-1:0] = period;
      default:    rdata[CNT_W-1:0] = snap;
    endcase
  end

`ifdef TIMER_PWM_EN
  logic [CNT_W-1:0] cmp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp <= '0;
      pwm <= 1'b0;
    end else begin
      if (wr_cmp)
        cmp <= wdata[CNT_W-1:0];
      pwm <= (cnt <= cmp) & run;
    end
  end

  always_comb begin
    cmp_rdata            = '0;
    cmp_rdata[CNT_W-1:0] = cmp;
  end
`else
  assign pwm = 1'b0;
`endif

endmodule

// File: rtl/avalon_multi_timer.sv
// NUM_CH independent interval timers behind one Avalon-MM slave: address decode, global page, read mux.
// Global CH_MASK lives in bits [NUM_CH+7:8]; a write there with START/STOP acts on the mask being written.
// TIMER_PWM_EN adds one CMP page per channel at page index channel + NUM_CH + 1.
module avalon_multi_timer
  import timer_pkg::*;
#(
  parameter  int          NUM_CH         = 4,
  parameter  int          CNT_W          = 32,
  parameter  int          PRESC_W        = 8,
  parameter  int unsigned DEFAULT_PERIOD = 49999,
  localparam int          ADDR_W         = calc_addr_w(NUM_CH, PWM_EN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int PAGE_W = ADDR_W - 2;

  logic              wr, g_wr, g_start, g_stop;
  logic [PAGE_W-1:0] page;
  logic [1:0]        reg_sel;
  logic [NUM_CH-1:0] ch_mask;
  logic [31:0]       rd_next;
  logic [31:0]       ch_rdata [NUM_CH];
`ifdef TIMER_PWM_EN
  logic [31:0]       cmp_rdata [NUM_CH];
`endif

  assign wr      = chipselect & ~write_n;
  assign page    = address[ADDR_W-1:2];
  assign reg_sel = address[1:0];
  assign g_wr    = wr & (page == PAGE_W'(NUM_CH)) & (reg_sel == REG_CH_MASK);
  assign g_start = g_wr & writedata[CTRL_START];
  assign g_stop  = g_wr & writedata[CTRL_STOP];
  assign irq     = |irq_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = wr & (page == PAGE_W'(i));
`ifdef TIMER_PWM_EN
    logic sel_cmp;
    assign sel_cmp = wr & (page == PAGE_W'(i + NUM_CH + 1)) & (reg_sel == REG_CMP);
`endif

    timer_channel #(
      .CNT_W          (CNT_W),
      .PRESC_W        (PRESC_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_status (sel & (reg_sel == REG_STATUS)),
      .wr_ctrl   (sel & (reg_sel == REG_CTRL)),
      .wr_period (sel & (reg_sel == REG_PERIOD)),
      .wr_snap   (sel & (reg_sel == REG_SNAP)),
`ifdef TIMER_PWM_EN
      .wr_cmp    (sel_cmp),
      .cmp_rdata (cmp_rdata[i]),
`endif
      .wdata     (writedata),
      .g_start   (g_start & writedata[CH_MASK_LSB + i]),
      .g_stop    (g_stop & writedata[CH_MASK_LSB + i]),
      .reg_sel   (reg_sel),
      .rdata     (ch_rdata[i]),
      .irq       (irq_vec[i]),
      .pwm       (pwm_out[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ch_mask <= '0;
    else if (g_wr)
      ch_mask <= writedata[CH_MASK_LSB +: NUM_CH];
  end

  always_comb begin
    rd_next = '0;
    if (page == PAGE_W'(NUM_CH)) begin
      if (reg_sel == REG_IRQ_PEND)
        rd_next[NUM_CH-1:0] = irq_vec;
      else if (reg_sel == REG_CH_MASK)
        rd_next[CH_MASK_LSB +: NUM_CH] = ch_mask;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (page == PAGE_W'(i))
        rd_next = ch_rdata[i];
`ifdef TIMER_PWM_EN
      if ((page == PAGE_W'(i + NUM_CH + 1)) && (reg_sel == REG_CMP))
        rd_next = cmp_rdata[i];
`endif
    end
  end

  // Read data follows the address every cycle, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= rd_next;
  end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer (default parameters, NUM_CH = 4).
// Register table first, then hand-written timing sequences; TIMER_PWM_EN selects the PWM check.
module tb_avalon_multi_timer;

`ifdef TIMER_PWM_EN
  localparam int AW = 6;
`else
  localparam int AW = 5;
`endif
  localparam int GPAGE = 4;

  typedef struct {
    bit          wr;
    int unsigned addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          chipselect;
  logic          write_n;
  logic [AW-1:0] address;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;
  logic [3:0]    irq_vec;
  logic [3:0]    pwm_out;

  int checks   = 0;
  int failures = 0;
  bit pwm_any  = 1'b0;

  avalon_multi_timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int unsigned a(input int page, input int r);
    return page * 4 + r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, return 1 time unit after the rising edge.
  task automatic bus_cycle(input bit wr, input int unsigned addr, input logic [31:0] data);
    @(negedge clk);
    chipselect = wr;
    write_n    = ~wr;
    address    = AW'(addr);
    writedata  = data;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    pwm_any    = pwm_any | (|pwm_out);
  endtask

  task automatic idle();
    bus_cycle(1'b0, a(GPAGE, 2), 32'h0);
  endtask

  vec_t vecs[$];
  bit   to_exp, to_prev, clr;
  int   pwm_high;

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_irq_vec", {28'b0, irq_vec}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_pwm_out", {28'b0, pwm_out}, 32'h0);

    // ---------------- register table ----------------
    vecs.push_back('{1'b0, a(0, 2), 32'h0, 32'd49999, "rst_ch0_period"});
    vecs.push_back('{1'b0, a(0, 0), 32'h0, 32'h0, "rst_ch0_status"});
    vecs.push_back('{1'b0, a(0, 1), 32'h0, 32'h0, "rst_ch0_ctrl"});
    vecs.push_back('{1'b0, a(0, 3), 32'h0, 32'h0, "rst_ch0_snap"});
    vecs.push_back('{1'b0, a(3, 2), 32'h0, 32'd49999, "rst_ch3_period"});
    vecs.push_back('{1'b0, a(GPAGE, 0), 32'h0, 32'h0, "rst_irq_pend"});
    vecs.push_back('{1'b0, a(GPAGE, 1), 32'h0, 32'h0, "rst_ch_mask"});
    vecs.push_back('{1'b0, a(GPAGE, 2), 32'h0, 32'h0, "unmapped_global"});
    vecs.push_back('{1'b0, a(5, 0), 32'h0, 32'h0, "unmapped_page5"});
    vecs.push_back('{1'b1, a(1, 1), 32'hFFFF_AB03, 32'h0, ""});
    vecs.push_back('{1'b0, a(1, 1), 32'h0, 32'h0000_AB03, "ch1_ctrl_rw"});
    vecs.push_back('{1'b1, a(1, 2), 32'hFFFF_FFFF, 32'h0, ""});
    vecs.push_back('{1'b0, a(1, 2), 32'h0, 32'hFFFF_FFFF, "ch1_period_max"});
    vecs.push_back('{1'b1, a(3, 3), 32'h1234_5678, 32'h0, ""});
    vecs.push_back('{1'b0, a(3, 3), 32'h0, 32'd49999, "ch3_snap_idle"});
    vecs.push_back('{1'b1, a(GPAGE, 1), 32'h0000_0300, 32'h0, ""});
    vecs.push_back('{1'b0, a(GPAGE, 1), 32'h0, 32'h0000_0300, "ch_mask_rw"});
    vecs.push_back('{1'b1, a(GPAGE, 1), 32'h0, 32'h0, ""});
    vecs.push_back('{1'b0, a(1, 0), 32'h0, 32'h0, "ch1_status_stopped"});

    foreach (vecs[k]) begin
      bus_cycle(vecs[k].wr, vecs[k].addr, vecs[k].data);
      if (!vecs[k].wr)
        check(vecs[k].name, readdata, vecs[k].exp);
    end

    // ---------------- one-shot on ch0: PERIOD=9, PRESC=0 ----------------
    bus_cycle(1'b1, a(0, 2), 32'd9);
    bus_cycle(1'b1, a(0, 1), 32'h5);
    for (int t = 1; t <= 10; t++) begin
      idle();
      if (t == 9)  check("oneshot_irq_t9", {31'b0, irq}, 32'h0);
      if (t == 10) check("oneshot_irq_t10", {31'b0, irq}, 32'h1);
    end
    check("oneshot_irq_vec", {28'b0, irq_vec}, 32'h1);
    bus_cycle(1'b0, a(0, 0), 32'h0);
    check("oneshot_status", readdata, 32'h1);
    bus_cycle(1'b1, a(0, 0), 32'h1);
    check("oneshot_irq_cleared", {31'b0, irq}, 32'h0);

    // ---------------- continuous on ch1: PERIOD=3, PRESC=2 -> every 12 clocks ----------------
    bus_cycle(1'b1, a(1, 2), 32'd3);
    bus_cycle(1'b1, a(1, 1), 32'h207);
    to_exp = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      clr = (t == 6) || (t == 18) || (t == 30) || (t == 36) || (t == 42) || (t == 54);
      if (clr)          bus_cycle(1'b1, a(1, 0), 32'h1);
      else if (t == 20) bus_cycle(1'b1, a(1, 3), 32'h0);
      else if (t == 21) bus_cycle(1'b0, a(1, 3), 32'h0);
      else if (t == 50) bus_cycle(1'b0, a(1, 0), 32'h0);
      else              idle();
      to_prev = to_exp;
      to_exp  = ((t % 12) == 0) | (to_exp & ~clr);
      if (t == 36)
        check("to_clear_collision", {31'b0, irq_vec[1]}, 32'h1);
      else
        check($sformatf("cont_irq_t%0d", t), {31'b0, irq_vec[1]}, {31'b0, to_exp});
      if (t == 21) check("cont_snap", readdata, 32'd1);
      if (t == 50) check("cont_status_run", readdata, {30'b0, 1'b1, to_prev});
    end
    bus_cycle(1'b1, a(1, 1), 32'h8);

    // START and STOP together: START wins; strobes read back as 0.
    bus_cycle(1'b1, a(2, 1), 32'hC);
    bus_cycle(1'b0, a(2, 0), 32'h0);
    check("start_stop_run", readdata, 32'h2);
    bus_cycle(1'b0, a(2, 1), 32'h0);
    check("ctrl_strobes_read0", readdata, 32'h0);

    // ---------------- global start of ch0 and ch2 ----------------
    for (int ch = 0; ch < 4; ch++) begin
      bus_cycle(1'b1, a(ch, 2), 32'd5);
      bus_cycle(1'b1, a(ch, 0), 32'h1);
      bus_cycle(1'b1, a(ch, 1), 32'h1);
    end
    bus_cycle(1'b1, a(GPAGE, 1), 32'h0000_0504);
    bus_cycle(1'b0, a(0, 0), 32'h0);
    check("gstart_ch0_run", readdata, 32'h2);
    bus_cycle(1'b0, a(2, 0), 32'h0);
    check("gstart_ch2_run", readdata, 32'h2);
    bus_cycle(1'b0, a(1, 0), 32'h0);
    check("gstart_ch1_idle", readdata, 32'h0);
    bus_cycle(1'b0, a(3, 0), 32'h0);
    check("gstart_ch3_idle", readdata, 32'h0);
    idle();
    check("gstart_irq_vec_t5", {28'b0, irq_vec}, 32'h0);
    idle();
    check("gstart_irq_vec_t6", {28'b0, irq_vec}, 32'h5);
    check("gstart_irq", {31'b0, irq}, 32'h1);
    bus_cycle(1'b0, a(GPAGE, 0), 32'h0);
    check("gstart_irq_pend", readdata, 32'h5);
    bus_cycle(1'b0, a(GPAGE, 1), 32'h0);
    check("gstart_ch_mask", readdata, 32'h0000_0500);

    // ---------------- asynchronous reset mid-count ----------------
    bus_cycle(1'b1, a(0, 1), 32'h7);
    idle();
    idle();
    bus_cycle(1'b0, a(0, 2), 32'h0);
    check("pre_reset_period", readdata, 32'd5);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    check("async_rst_irq_vec", {28'b0, irq_vec}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_cycle(1'b0, a(0, 2), 32'h0);
    check("post_rst_period", readdata, 32'd49999);
    bus_cycle(1'b0, a(0, 0), 32'h0);
    check("post_rst_status", readdata, 32'h0);
    bus_cycle(1'b0, a(GPAGE, 1), 32'h0);
    check("post_rst_ch_mask", readdata, 32'h0);

`ifdef TIMER_PWM_EN
    // ---------------- PWM on ch0: PERIOD=9, CMP=4, continuous ----------------
    bus_cycle(1'b1, a(0, 2), 32'd9);
    bus_cycle(1'b1, a(5, 3), 32'd4);
    bus_cycle(1'b0, a(5, 3), 32'h0);
    check("pwm_cmp_rw", readdata, 32'd4);
    bus_cycle(1'b1, a(0, 1), 32'h6);
    pwm_high = 0;
    for (int t = 1; t <= 30; t++) begin
      idle();
      if (t > 10 && pwm_out[0]) pwm_high++;
    end
    check("pwm_duty_20clk", pwm_high, 32'd10);
`else
    check("pwm_out_tied0", {31'b0, pwm_any}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
